// File: rtl/mux_sync_launcher_if.sv
// Word-in / serial-launch handshake bundle for mux_sync_launcher.
// master offers words; slave launches them as EN-qualified serial bits.
interface mux_sync_launcher_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             EN;
  logic             data_out;
  logic             busy;
  logic             done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  EN,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output EN,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/mux_sync_launcher.sv
// Serial mux-sync launcher: shifts a word out LSB first, each bit
// framed by SETUP cycles, a one-cycle EN strobe and HOLD cycles.
module mux_sync_launcher #(
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int HOLD  = 4
) (
  input  logic               clk1,
  input  logic               rst_clk1,
  mux_sync_launcher_if.slave bus
);

  localparam int MAXC   = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW     = $clog2(WIDTH);
  localparam int HEND_N = HOLD - 1;
  // The done/IDLE cycle doubles as the last bit's final hold cycle
  localparam int HEND_L = (HOLD > 1) ? HOLD - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-2:0] r_sh;
  logic             r_en;
  logic             r_dout;
  logic             r_done;

  logic w_accept;
  logic w_last;
  logic w_hold_end;
  logic w_adv;
  logic w_en_nxt;
  logic w_done_nxt;
  logic w_dout_nxt;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_last     = (r_bit == BW'(WIDTH - 1));
  assign w_hold_end = w_last ? (r_cnt == CW'(HEND_L))
                             : (r_cnt == CW'(HEND_N));

  always_ff @(posedge clk1 or negedge rst_clk1) begin
    if (!rst_clk1) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_en    <= 1'b0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_dout  <= w_dout_nxt;
      if (w_nxt != r_state || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_accept) begin
        r_bit <= '0;
        r_sh  <= bus.in_data[WIDTH-1:1];
      end else if (w_adv) begin
        r_bit <= r_bit + BW'(1);
        r_sh  <= r_sh >> 1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_nxt = S_SETUP;
      S_SETUP: if (r_cnt == CW'(SETUP - 1)) w_nxt = S_PULSE;
      S_PULSE: w_nxt = (w_last && HOLD == 1) ? S_IDLE : S_HOLD;
      S_HOLD:  if (w_hold_end) w_nxt = w_last ? S_IDLE : S_SETUP;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adv      = (r_state == S_HOLD) && (w_nxt == S_SETUP);
    w_en_nxt   = (w_nxt == S_PULSE);
    w_done_nxt = (r_state != S_IDLE) && (w_nxt == S_IDLE);
    w_dout_nxt = r_dout;
    if (w_accept)
      w_dout_nxt = bus.in_data[0];
    else if (w_adv)
      w_dout_nxt = r_sh[0];
  end

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.EN       = r_en;
  assign bus.data_out = r_dout;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_mux_sync_launcher.sv
// Directed bench for mux_sync_launcher with an EN/done scoreboard.
module tb_mux_sync_launcher;

  localparam int W  = 8;
  localparam int SU = 1;
  localparam int HO = 4;
  localparam int PER = SU + 1 + HO;
  localparam int DUR = W * PER;

  typedef struct {
    int   t;
    logic b;
  } en_t;

  logic clk1;
  logic rst_clk1;

  mux_sync_launcher_if #(.WIDTH(W)) bus ();

  mux_sync_launcher #(
    .WIDTH(W),
    .SETUP(SU),
    .HOLD (HO)
  ) dut (
    .clk1    (clk1),
    .rst_clk1(rst_clk1),
    .bus     (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int   t = 0;
  int   checks = 0;
  int   errors = 0;
  int   hold_left = 0;
  int   a;
  logic hold_val = 1'b0;
  logic prev_dout = 1'b0;
  en_t  q[$];
  int   dq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int acc, input logic [7:0] d);
    en_t e;
    for (int k = 0; k < W; k++) begin
      e.t = acc + SU + 1 + PER * k;
      e.b = d[k];
      q.push_back(e);
    end
    dq.push_back(acc + DUR);
  endtask

  task automatic mon();
    en_t e;
    int  d;
    if (hold_left > 0) begin
      chk("hold_stable", bus.data_out, hold_val);
      hold_left--;
    end
    if (bus.EN === 1'b1) begin
      chk("setup_stable", bus.data_out, prev_dout);
      if (q.size() == 0) begin
        chk("en_unexpected", bus.EN, 0);
      end else begin
        e = q.pop_front();
        chk("en_time", t, e.t);
        chk("en_bit", bus.data_out, e.b);
      end
      hold_left = HO;
      hold_val  = bus.data_out;
    end
    if (bus.done === 1'b1) begin
      chk("done_ready", bus.in_ready, 1);
      if (dq.size() == 0) begin
        chk("done_unexpected", bus.done, 0);
      end else begin
        d = dq.pop_front();
        chk("done_time", t, d);
      end
    end
    prev_dout = bus.data_out;
  endtask

  task automatic tick();
    @(negedge clk1);
    t++;
    mon();
  endtask

  initial begin
    rst_clk1     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) tick();
    chk("rst_en", bus.EN, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // First edge after release accepts the word already on offer
    rst_clk1 = 1'b1;
    a = t;
    push_word(a, 8'hA5);
    tick();
    chk("acc_busy", bus.busy, 1);
    chk("acc_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    while (t < a + 10) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    repeat (5) begin
      tick();
      chk("rej_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    while (t < a + DUR + 8) tick();
    chk("w1_en_left", q.size(), 0);
    chk("w1_done_left", dq.size(), 0);
    chk("idle_dout", bus.data_out, 1);
    chk("idle_en", bus.EN, 0);
    chk("idle_busy", bus.busy, 0);

    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    a = t;
    push_word(a, 8'hFF);
    push_word(a + DUR, 8'h00);
    tick();
    bus.in_data = 8'h00;
    while (t < a + DUR + 1) tick();
    chk("b2b_busy", bus.busy, 1);
    bus.in_valid = 1'b0;
    while (t < a + 2 * DUR + 4) tick();
    chk("b2b_en_left", q.size(), 0);
    chk("b2b_done_left", dq.size(), 0);
    chk("b2b_dout", bus.data_out, 0);

    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    a = t;
    push_word(a, 8'h5A);
    tick();
    bus.in_valid = 1'b0;
    while (t < a + SU + 1 + 2 * PER) tick();
    chk("third_en", bus.EN, 1);
    q.delete();
    dq.delete();
    hold_left = 0;
    #2 rst_clk1 = 1'b0;
    #1;
    chk("mrst_en", bus.EN, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_dout", bus.data_out, 0);
    chk("mrst_done", bus.done, 0);
    rst_clk1  = 1'b1;
    prev_dout = 1'b0;
    repeat (60) tick();
    chk("mrst_idle", bus.in_ready, 1);

    bus.in_valid = 1'b1;
    bus.in_data  = 8'h81;
    a = t;
    push_word(a, 8'h81);
    tick();
    bus.in_valid = 1'b0;
    while (t < a + DUR + 8) tick();
    chk("w4_en_left", q.size(), 0);
    chk("w4_done_left", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sync_launcher.md
MUX_SYNC_LAUNCHER -- requirements
Module: mux_sync_launcher

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; SHALL be at least 2.
REQ-002 Parameter SETUP, default 1: clk1 cycles data is stable before the EN pulse; SHALL be at least 1.
REQ-003 Parameter HOLD, default 4: clk1 cycles data stays stable after the EN pulse, covering destination capture; SHALL be at least 1.
REQ-004 Port clk1, input, 1: sole clock; every register SHALL update on its rising edge.
REQ-005 Port rst_clk1, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: a parallel word is offered.
REQ-007 Port in_data, input, WIDTH: the offered word.
REQ-008 Port in_ready, output, 1: block can accept a word this cycle.
REQ-009 Port EN, output, 1: one-cycle launch strobe, driven to the crossing stage's EN.
REQ-010 Port data_out, output, 1: serial bit, driven to the crossing stage's data_in.
REQ-011 Port busy, output, 1: a word is being launched.
REQ-012 Port done, output, 1: one-cycle pulse when the last bit's HOLD completes.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, PULSE and HOLD.
REQ-014 Accept SHALL occur at a rising edge where in_valid=1 and in_ready=1; in_data SHALL be latched into a shift register at that edge.
REQ-015 in_ready SHALL equal 1 exactly when state=IDLE; it SHALL be combinational from state.
REQ-016 in_valid or in_data changes while not IDLE SHALL be ignored; the latched word SHALL be unaffected.
REQ-017 On accept, the next state SHALL be SETUP with bit index 0 and data_out = in_data[0] (LSB first).
REQ-018 SETUP SHALL last SETUP cycles with EN=0, then go to PULSE.
REQ-019 PULSE SHALL last exactly 1 cycle with EN=1, then go to HOLD.
REQ-020 HOLD SHALL last HOLD cycles with EN=0.
REQ-021 After the HOLD of bit index i < WIDTH-1, the next state SHALL be SETUP with data_out = bit i+1.
REQ-022 After the HOLD of bit WIDTH-1, the next state SHALL be IDLE and done=1 for that one cycle.
REQ-023 data_out SHALL change only on the edge entering SETUP; it SHALL be constant through SETUP, PULSE and HOLD of a bit.
REQ-024 In IDLE, data_out SHALL hold the last launched bit; EN SHALL be 0.
REQ-025 EN, data_out and done SHALL be registered outputs with no combinational path from inputs.
REQ-026 Per-bit period SHALL be SETUP+1+HOLD cycles; word duration SHALL be WIDTH*(SETUP+1+HOLD) cycles (48 at defaults).
REQ-027 busy SHALL be 1 in SETUP, PULSE and HOLD, and 0 in IDLE.
REQ-028 Back-to-back words: a word offered in the done cycle (state IDLE) SHALL be accepted there, giving no extra idle gap.
REQ-029 Cycle and bit counters SHALL be sized clog2 of their maximum count and SHALL never wrap within a word.

Reset
REQ-030 rst_clk1=0 SHALL immediately force state IDLE, EN=0, data_out=0, done=0, busy=0 and counters=0, regardless of the clock.
REQ-031 Reset asserted mid-word SHALL abandon the word; no further EN pulse SHALL occur until a new accept.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_clk1 deasserts.

Verification
REQ-033 Reset: hold rst_clk1=0 with in_valid=1 -> EN=0, data_out=0, in_ready=1, busy=0, no accept.
REQ-034 Single word: in_data=8'hA5 for one cycle -> EN pulses at cycles 2, 8, ..., 44 after accept; the data_out sequence sampled at EN is 1,0,1,0,0,1,0,1; done at cycle 48.
REQ-035 Busy rejection: present 8'h3C mid-word -> in_ready=0, the word is ignored, and the serial output of the first word is unchanged.
REQ-036 Back-to-back: hold in_valid=1 with 8'hFF then 8'h00 -> the second accept falls in the done cycle, and EN spacing stays 6 cycles across the word boundary.
REQ-037 Mid-word reset: pulse rst_clk1 low after the 3rd EN -> EN=0 at once, state IDLE, and no further EN pulses until a new word is accepted.
REQ-038 Timing check: for every EN=1 cycle, data_out is equal in the SETUP cycle before it and in all HOLD cycles after it.
